// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, req/ack memory port, prefetch queue to decode.
// Optional FETCH_STATS_EN adds FetchCount/FlushCount statistics outputs.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 24,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic [3:0]         Opcode,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        FetchCount,
    output logic [15:0]        FlushCount
`endif
);

    localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DISCARD} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    post_cnt;
    logic [ENTRY_W-1:0]  queue_q [QDEPTH];
    logic [ENTRY_W-1:0]  entry_d;
    logic [ENTRY_W-1:0]  head;
    logic                push, pop, flush;

    assign InstrValid = (count_q != '0);
    assign pop        = InstrValid && InstrReady;
    assign head       = InstrValid ? queue_q[rd_ptr_q] : '0;
    assign Instr      = head[ENTRY_W-1:ADDR_W];
    assign InstrPC    = head[ADDR_W-1:0];
    assign Opcode     = head[ENTRY_W-1 -: 4];

    // While in DISCARD, pc_q still holds the stale address; the new target waits in target_q.
    assign IMemReq  = (state_q == FETCH) || (state_q == DISCARD);
    assign IMemAddr = pc_q;
    assign entry_d  = {IMemData, pc_q};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        push     = 1'b0;
        flush    = 1'b0;
        post_cnt = pop ? count_q : count_q + CNT_W'(1);

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (IMemAck) begin
                    push    = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = (post_cnt < CNT_W'(QDEPTH)) ? FETCH : FULL;
                end
            end
            FULL: begin
                if (pop) state_d = FETCH;
            end
            DISCARD: begin
                if (IMemAck) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // An outstanding request cannot be withdrawn, so its ack is absorbed in DISCARD.
        if (Redirect) begin
            flush = 1'b1;
            push  = 1'b0;
            case (state_q)
                FETCH, DISCARD: begin
                    if (IMemAck) begin
                        pc_d    = RedirectPC;
                        state_d = FETCH;
                    end else begin
                        target_d = RedirectPC;
                        state_d  = DISCARD;
                    end
                end
                default: begin
                    pc_d    = RedirectPC;
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage is data only; occupancy alone decides what is visible.
    always_ff @(posedge Clock) begin
        if (push) queue_q[wr_ptr_q] <= entry_d;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
        flush_count_d = flush_count_q + 16'(Redirect);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign FetchCount = fetch_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: bench-side memory and decode, queue-based reference model.
module tb_instr_fetch_unit;

    localparam int               ADDR_W   = 16;
    localparam int               INSTR_W  = 24;
    localparam int               QDEPTH   = 2;
    localparam logic [15:0]      RESET_PC = 16'hFFFE;

    logic               Clock = 1'b0;
    logic               Reset_n;
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck = 1'b0;
    logic [INSTR_W-1:0] IMemData = '0;
    logic               InstrValid;
    logic               InstrReady = 1'b0;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic [3:0]         Opcode;
    logic               Redirect = 1'b0;
    logic [ADDR_W-1:0]  RedirectPC = '0;
`ifdef FETCH_STATS_EN
    logic [31:0]        FetchCount;
    logic [15:0]        FlushCount;
`endif

    instr_fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
        .InstrPC(InstrPC), .Opcode(Opcode),
        .Redirect(Redirect), .RedirectPC(RedirectPC)
`ifdef FETCH_STATS_EN
        , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    entry_t        mq[$];
    int unsigned   delays[$];
    logic [15:0]   popped[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            wait_cnt = -1;
    int            ready_mode = 1;
    int            max_delay  = 0;
    int            redir_pct  = 0;
    int            n_pops = 0;
    logic          just_reset = 1'b0;
    logic          stale = 1'b0;
    logic          prev_wait = 1'b0;
    logic [15:0]   prev_addr = '0;
    logic [15:0]   exp_fetch_pc = RESET_PC;
    logic          force_redir = 1'b0;
    logic [15:0]   force_pc = '0;
    logic [23:0]   base = 24'h1A0000;
    logic [31:0]   exp_fetch_cnt = '0;
    logic [15:0]   exp_flush_cnt = '0;

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        return base + 24'(a);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef FETCH_STATS_EN
        check_eq("fetch_count", FetchCount, exp_fetch_cnt);
        check_eq("flush_count", FlushCount, exp_flush_cnt);
`endif
    endtask

    // Asserts reset asynchronously, checks the reset-state outputs, releases at the next negedge.
    task automatic do_reset();
        Reset_n    = 1'b0;
        IMemAck    = 1'b0;
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        #1;
        check_eq("rst_req",   IMemReq,    1'b0);
        check_eq("rst_addr",  IMemAddr,   RESET_PC);
        check_eq("rst_valid", InstrValid, 1'b0);
        check_eq("rst_instr", Instr,      24'h0);
        check_eq("rst_ipc",   InstrPC,    16'h0);
        check_eq("rst_opc",   Opcode,     4'h0);
        mq.delete();
        delays.delete();
        popped.delete();
        wait_cnt      = -1;
        stale         = 1'b0;
        prev_wait     = 1'b0;
        exp_fetch_pc  = RESET_PC;
        just_reset    = 1'b1;
        n_pops        = 0;
        exp_fetch_cnt = '0;
        exp_flush_cnt = '0;
        check_stats();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    // Called at a negedge: check outputs, drive inputs, advance the model across the next posedge.
    task automatic cycle();
        logic        ack, rdy, rd, pop;
        logic [15:0] rpc;
        if (prev_wait) begin
            check_eq("req_hold",  IMemReq,  1'b1);
            check_eq("addr_hold", IMemAddr, prev_addr);
        end
        check_eq("req", IMemReq, just_reset ? 1'b0 : (stale || mq.size() < QDEPTH));
        if (IMemReq && !stale) check_eq("fetch_addr", IMemAddr, exp_fetch_pc);
        check_eq("valid", InstrValid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("instr",  Instr,   mq[0].instr);
            check_eq("ipc",    InstrPC, mq[0].pc);
            check_eq("opcode", Opcode,  mq[0].instr[23:20]);
        end else begin
            check_eq("instr_zero",  Instr,   24'h0);
            check_eq("ipc_zero",    InstrPC, 16'h0);
            check_eq("opcode_zero", Opcode,  4'h0);
        end
        check_stats();

        ack = 1'b0;
        if (IMemReq) begin
            if (wait_cnt < 0) begin
                if (delays.size() != 0) wait_cnt = int'(delays.pop_front());
                else wait_cnt = int'($urandom_range(max_delay, 0));
            end
            if (wait_cnt == 0) begin
                ack      = 1'b1;
                wait_cnt = -1;
            end else begin
                wait_cnt--;
            end
        end
        if (ready_mode == 0)      rdy = 1'b0;
        else if (ready_mode == 1) rdy = 1'b1;
        else                      rdy = ($urandom_range(99, 0) < 70);
        if (force_redir) begin
            rd = 1'b1;
            rpc = force_pc;
            force_redir = 1'b0;
        end else begin
            rd  = ($urandom_range(99, 0) < redir_pct);
            rpc = 16'($urandom);
        end
        IMemAck    = ack;
        IMemData   = ack ? mem_word(IMemAddr) : 24'($urandom);
        InstrReady = rdy;
        Redirect   = rd;
        RedirectPC = rpc;

        pop = (mq.size() != 0) && rdy;
        if (pop) begin
            popped.push_back(mq[0].pc);
            mq.delete(0);
            n_pops++;
            exp_fetch_cnt++;
        end
        if (rd) begin
            mq.delete();
            exp_flush_cnt++;
            stale        = IMemReq && !ack;
            exp_fetch_pc = rpc;
        end else if (ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                mq.push_back('{instr: mem_word(exp_fetch_pc), pc: exp_fetch_pc});
                exp_fetch_pc = exp_fetch_pc + 16'd1;
            end
        end
        prev_wait  = IMemReq && !ack;
        prev_addr  = IMemAddr;
        just_reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cnt;
        Reset_n = 1'b0;
        @(negedge Clock);

        // Zero-wait memory, decode always ready: first word in cycle 2, then one per cycle, PC wraps.
        do_reset();
        max_delay = 0; ready_mode = 1; redir_pct = 0;
        run(2);
        check_eq("first_valid", InstrValid, 1'b1);
        check_eq("first_instr", Instr, 24'h1AFFFE);
        check_eq("first_pc", InstrPC, 16'hFFFE);
        check_eq("first_opc", Opcode, 4'h1);
        run(10);
        check_eq("throughput", n_pops, 10);
        check_eq("wrap_pc1", popped[1], 16'hFFFF);
        check_eq("wrap_pc2", popped[2], 16'h0000);

        // Decode stalled: queue fills to two entries and requests stop until a pop.
        do_reset();
        ready_mode = 0;
        run(5);
        check_eq("full_noreq", IMemReq, 1'b0);
        check_eq("full_valid", InstrValid, 1'b1);
        ready_mode = 1;
        run(1);
        check_eq("refetch_req", IMemReq, 1'b1);
        check_eq("refetch_addr", IMemAddr, 16'h0000);
        check_eq("popped_first", popped[0], 16'hFFFE);
        run(4);

        // Ack delayed three cycles: request held, exactly one push.
        do_reset();
        ready_mode = 1;
        delays.push_back(3);
        run(9);
        cnt = 0;
        foreach (popped[i]) if (popped[i] == 16'hFFFE) cnt++;
        check_eq("no_dup", cnt, 1);

        // Redirect to 0x0040 while the request to 0x0005 is pending.
        do_reset();
        ready_mode = 1;
        delays.push_back(2);
        force_redir = 1'b1; force_pc = 16'h0005;
        run(1);
        check_eq("pend_addr", IMemAddr, 16'h0005);
        force_redir = 1'b1; force_pc = 16'h0040;
        run(3);
        check_eq("disc_empty", InstrValid, 1'b0);
        check_eq("target_addr", IMemAddr, 16'h0040);
        run(6);
        cnt = 0;
        foreach (popped[i]) if (popped[i] == 16'h0005) cnt++;
        check_eq("stale_dropped", cnt, 0);
        check_eq("redir_first", popped[0], 16'h0040);

        // Reset pulsed while waiting on an ack with one entry queued.
        do_reset();
        ready_mode = 0;
        delays.push_back(0);
        delays.push_back(20);
        run(4);
        check_eq("pre_rst_valid", InstrValid, 1'b1);
        check_eq("pre_rst_req", IMemReq, 1'b1);
        do_reset();
        ready_mode = 1;
        run(1);
        check_eq("restart_addr", IMemAddr, RESET_PC);
        run(4);

        // Randomized traffic: variable latency, random backpressure and redirects.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            base       = {4'($urandom), 20'hA0000};
            max_delay  = 3;
            ready_mode = 2;
            redir_pct  = 6;
            run(1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
